// File: rtl/stream_pkg.sv
// stream_pkg: shared helpers for the stream_* blocks.
// Provides a thermometer lane mask and an elaboration-time parameter check macro.
`ifndef STREAM_PKG_SV
`define STREAM_PKG_SV

// Elaboration-time check; instantiate inside a module body with a unique label.
`define STREAM_STATIC_ASSERT(lbl, cond, msg) \
  if (!(cond)) begin : lbl \
    $fatal(1, msg); \
  end

package stream_pkg;

  // Widest lane count any stream block may use with lane_mask.
  localparam int unsigned MAX_RATIO = 64;

  // Thermometer mask with lanes 0..cnt set; callers truncate to their lane count.
  function automatic logic [MAX_RATIO-1:0] lane_mask(input int unsigned cnt);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      if (i <= cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`endif

// File: rtl/stream_upsizer_if.sv
// stream_upsizer_if: narrow input stream and wide output stream of stream_upsizer.
// slave = the upsizer's view, master = the environment's view.
interface stream_upsizer_if #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [IN_WIDTH-1:0]       in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [IN_WIDTH*RATIO-1:0] out_data;
  logic [RATIO-1:0]          out_keep;
  logic                      out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow beats into one wide beat behind a holding register.
// Optional macro STREAM_UPSIZER_LAST_EN: in_last closes a partial wide beat with out_last set.
module stream_upsizer
  import stream_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 4
) (
  input logic             clk,
  input logic             rst,
  stream_upsizer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(RATIO);
  localparam int unsigned OUT_W = IN_WIDTH * RATIO;

  `STREAM_STATIC_ASSERT(g_ratio_check,
    (RATIO >= 2) && ((RATIO & (RATIO - 1)) == 0) && (RATIO <= MAX_RATIO),
    "stream_upsizer: RATIO must be a power of 2, >= 2 and <= MAX_RATIO")

  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [RATIO-2:0][IN_WIDTH-1:0]    buf_q, buf_d;
  logic                              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]                  out_data_q, out_data_d;
  logic [RATIO-1:0]                  out_keep_q, out_keep_d;
  logic                              out_last_q, out_last_d;

  logic                              in_ready_c;
  logic                              accept_c;
  logic                              last_c;
  logic                              complete_c;
  logic [RATIO-1:0][IN_WIDTH-1:0]    asm_c;

  // Input side only waits on a full, unconsumed output register.
  assign in_ready_c = !out_valid_q || bus.out_ready;

`ifdef STREAM_UPSIZER_LAST_EN
  assign last_c = bus.in_last;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign last_c         = 1'b0;
`endif

  // Lane counter, assembly buffer and output register next-state.
  always_comb begin
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    accept_c   = bus.in_valid && in_ready_c;
    complete_c = accept_c && ((cnt_q == CNT_W'(RATIO - 1)) || last_c);

    // Completed word: stored lanes below cnt, current beat at cnt, zeros above.
    asm_c = '0;
    for (int i = 0; i < int'(RATIO) - 1; i++) begin
      if (CNT_W'(i) < cnt_q) asm_c[i] = buf_q[i];
    end
    asm_c[cnt_q] = bus.in_data;

    if (accept_c) begin
      for (int i = 0; i < int'(RATIO) - 1; i++) begin
        if (cnt_q == CNT_W'(i)) buf_d[i] = bus.in_data;
      end
      cnt_d = complete_c ? '0 : cnt_q + CNT_W'(1);
    end

    if (complete_c) begin
      out_valid_d = 1'b1;
      out_data_d  = asm_c;
`ifdef STREAM_UPSIZER_LAST_EN
      out_keep_d  = RATIO'(lane_mask(32'(cnt_q)));
      out_last_d  = bus.in_last;
`else
      out_keep_d  = '1;
      out_last_d  = 1'b0;
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops partial lanes and any pending output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: directed bench for stream_upsizer with IN_WIDTH=8, RATIO=4.
// Honours STREAM_UPSIZER_LAST_EN the same way as the design.
module tb_stream_upsizer;
  localparam int unsigned IN_WIDTH = 8;
  localparam int unsigned RATIO    = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   stall_cnt;
  bit   rand_ready;

  logic [31:0] mon_data[$];
  logic [3:0]  mon_keep[$];
  logic        mon_last[$];

  stream_upsizer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

  stream_upsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every consumed wide beat.
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_data.push_back(bus.out_data);
      mon_keep.push_back(bus.out_keep);
      mon_last.push_back(bus.out_last);
    end
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_keep.delete();
    mon_last.delete();
  endtask

  // Present one beat and return one tick after the edge that accepted it.
  task automatic feed(input logic [7:0] d, input logic l);
    bit ok;
    int cyc;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 100) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      ok = bus.in_ready;
      if (!ok) stall_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: beat %h not accepted within 100 cycles", d);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", bus.out_data); end
    checks++; if (bus.out_keep !== 4'h0) begin errors++; $display("FAIL reset_out_keep: got %h want 0", bus.out_keep); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    feed(8'h11, 1'b0);
    feed(8'h22, 1'b0);
    feed(8'h33, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
    feed(8'h44, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h44332211) begin errors++; $display("FAIL basic_data: got %h want 44332211", bus.out_data); end
    checks++; if (bus.out_keep !== 4'hF) begin errors++; $display("FAIL basic_keep: got %h want f", bus.out_keep); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL basic_last: got %b want 0", bus.out_last); end
    idle(1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", bus.out_valid); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    logic [31:0] got;
    clear_mon();
    stall_cnt     = 0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 64; b++) feed(8'(b + 1), 1'b0);
    idle(2);
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL b2b_in_ready_drops: got %0d want 0", stall_cnt); end
    checks++; if (mon_data.size() !== 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", mon_data.size()); end
    for (int k = 0; k < 16; k++) begin
      exp = {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)};
      got = (k < mon_data.size()) ? mon_data[k] : 32'hx;
      checks++; if (got !== exp) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", k, got, exp); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] got;
    clear_mon();
    bus.out_ready = 1'b0;
    feed(8'h01, 1'b0);
    feed(8'h02, 1'b0);
    feed(8'h03, 1'b0);
    feed(8'h04, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d: got %b want 0", c, bus.in_ready); end
      checks++; if (bus.out_data !== 32'h04030201) begin errors++; $display("FAIL stall_hold%0d: got %h want 04030201", c, bus.out_data); end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    feed(8'h05, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", bus.out_valid); end
    feed(8'h06, 1'b0);
    feed(8'h07, 1'b0);
    feed(8'h08, 1'b0);
    idle(2);
    checks++; if (mon_data.size() !== 2) begin errors++; $display("FAIL stall_count: got %0d want 2", mon_data.size()); end
    got = (mon_data.size() > 0) ? mon_data[0] : 32'hx;
    checks++; if (got !== 32'h04030201) begin errors++; $display("FAIL stall_first: got %h want 04030201", got); end
    got = (mon_data.size() > 1) ? mon_data[1] : 32'hx;
    checks++; if (got !== 32'h08070605) begin errors++; $display("FAIL stall_second: got %h want 08070605", got); end
  endtask

  task automatic test_last();
    bus.out_ready = 1'b1;
    feed(8'hAA, 1'b0);
    feed(8'hBB, 1'b1);
`ifdef STREAM_UPSIZER_LAST_EN
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL last_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data[15:0] !== 16'hBBAA) begin errors++; $display("FAIL last_data: got %h want bbaa", bus.out_data[15:0]); end
    checks++; if (bus.out_keep !== 4'h3) begin errors++; $display("FAIL last_keep: got %h want 3", bus.out_keep); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL last_flag: got %b want 1", bus.out_last); end
    feed(8'hCC, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL last_restart: got %b want 0", bus.out_valid); end
    feed(8'hDD, 1'b0);
    feed(8'hEE, 1'b0);
    feed(8'hFF, 1'b1);
    checks++; if (bus.out_data !== 32'hFFEEDDCC) begin errors++; $display("FAIL last_full_data: got %h want ffeeddcc", bus.out_data); end
    checks++; if (bus.out_keep !== 4'hF) begin errors++; $display("FAIL last_full_keep: got %h want f", bus.out_keep); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL last_full_flag: got %b want 1", bus.out_last); end
`else
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL nolast_early: got %b want 0", bus.out_valid); end
    feed(8'hCC, 1'b0);
    feed(8'hDD, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nolast_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL nolast_data: got %h want ddccbbaa", bus.out_data); end
    checks++; if (bus.out_keep !== 4'hF) begin errors++; $display("FAIL nolast_keep: got %h want f", bus.out_keep); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL nolast_flag: got %b want 0", bus.out_last); end
`endif
    idle(2);
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    feed(8'h10, 1'b0);
    feed(8'h20, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    feed(8'h5A, 1'b0);
    feed(8'h6B, 1'b0);
    feed(8'h7C, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early: got %b want 0", bus.out_valid); end
    feed(8'h8D, 1'b0);
    checks++; if (bus.out_data !== 32'h8D7C6B5A) begin errors++; $display("FAIL midrst_data: got %h want 8d7c6b5a", bus.out_data); end
    checks++; if (bus.out_keep !== 4'hF) begin errors++; $display("FAIL midrst_keep: got %h want f", bus.out_keep); end
    idle(2);
  endtask

  task automatic test_random_gaps();
    logic [7:0]  rd[40];
    logic [31:0] exp;
    logic [31:0] got;
    int          wait_cyc;
    clear_mon();
    for (int b = 0; b < 40; b++) rd[b] = 8'($urandom);
    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
      end
      feed(rd[b], 1'b0);
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    wait_cyc      = 0;
    while (mon_data.size() < 10 && wait_cyc < 20) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    checks++; if (mon_data.size() !== 10) begin errors++; $display("FAIL rand_count: got %0d want 10", mon_data.size()); end
    for (int k = 0; k < 10; k++) begin
      exp = {rd[4*k + 3], rd[4*k + 2], rd[4*k + 1], rd[4*k]};
      got = (k < mon_data.size()) ? mon_data[k] : 32'hx;
      checks++; if (got !== exp) begin errors++; $display("FAIL rand_word%0d: got %h want %h", k, got, exp); end
      if (k < mon_data.size()) begin
        checks++; if (mon_keep[k] !== 4'hF || mon_last[k] !== 1'b0) begin
          errors++; $display("FAIL rand_side%0d: got keep=%h last=%b want keep=f last=0", k, mon_keep[k], mon_last[k]);
        end
      end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    stall_cnt  = 0;
    rand_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_last();
    test_mid_reset();
    test_random_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
